vlg_resp_checker: RTL
=====================

// Module: vlg_resp_checker
// PURPOSE
//  Synthesizable response checker, the receiving end of the a/b stimulus path.
//  Compares a combinational reference output (z_ref, e.g. vlg_design1.z) against a
//  registered DUT output (z_dut, e.g. vlg_design2.z) after aligning z_ref by LATENCY clocks.
//  Reports per-cycle mismatches, error and match counts, the first failing cycle and a
//  final pass flag. Instantiated next to the DUTs in the bench or on-chip self-test.
// PARAMETERS
//  LATENCY  1   clocks z_dut lags z_ref; legal range 1..8
//  CNT_W    16  width of all counters; counters saturate at 2**CNT_W-1
// PORTS
//  clk            in   1      single clock; all logic samples on rising edge
//  rst_n          in   1      reset: synchronous, active-low
//  start          in   1      1-cycle pulse; begins a check run
//  stop           in   1      1-cycle pulse; ends or aborts a run
//  z_ref          in   1      reference output, sampled at clk edge only
//  z_dut          in   1      DUT registered output
//  chk_active     out  1      high while in CHECK
//  err_pulse      out  1      1-cycle pulse per detected mismatch
//  err_cnt        out  CNT_W  mismatches in current/last run
//  match_cnt      out  CNT_W  matching compares in current/last run
//  first_err_cyc  out  CNT_W  CHECK-cycle index (0-based) of first mismatch
//  done           out  1      high in DONE
//  pass           out  1      valid when done=1; 1 = err_cnt==0
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): FSM=IDLE; all outputs 0; delay line all 0;
//   first_err_cyc=all-ones (no error yet). Reset mid-run discards the run, no done.
//  Delay line: LATENCY-deep shift register of z_ref, shifts every cycle in every state.
//   z_aln = tap[LATENCY-1], i.e. z_ref from LATENCY edges earlier.
//  FSM states: IDLE, SETTLE, CHECK, DONE.
//   IDLE  : start -> SETTLE; clear err_cnt, match_cnt, cyc_cnt, pass;
//           first_err_cyc=all-ones. stop ignored.
//   SETTLE: stays exactly LATENCY cycles (pipeline fill), then -> CHECK.
//           stop -> IDLE (abort, done stays 0). start ignored.
//   CHECK : each edge compares z_aln vs z_dut.
//           Mismatch: err_pulse<=1, err_cnt+=1. If err_cnt was 0,
//           first_err_cyc<=cyc_cnt. Match: err_pulse<=0, match_cnt+=1.
//           cyc_cnt+=1 every CHECK cycle. start ignored.
//           stop -> DONE; the compare on that same edge is still performed and counted.
//   DONE  : done=1, pass=(final err_cnt==0); counters hold; err_pulse=0.
//           start -> SETTLE with the same clears as IDLE; done drops on that edge.
//  Latency: mismatch present before edge N -> err_pulse and new err_cnt visible after
//   edge N (registered, 1 cycle wide per mismatch; back-to-back mismatches keep it high).
//  chk_active=1 exactly while in CHECK. Outputs are registered, no comb paths in->out.
//  Saturation: err_cnt/match_cnt/cyc_cnt stop at all-ones, no wrap; err_pulse still
//   fires at saturation.
//  Simultaneous start+stop: in IDLE/DONE start wins; in SETTLE/CHECK stop wins.
//  Intra-cycle skew between DUT inputs (e.g. a/b changing 1 ns apart) is invisible by
//   design; only clock-edge values are compared.
// TESTING
//  T1 LATENCY=1, z_dut=z_ref delayed 1 clk, 20 random CHECK cycles, stop
//     -> done=1, pass=1, err_cnt=0, match_cnt=21 (stop cycle included).
//  T2 as T1, invert z_dut on CHECK cycle 5 only
//     -> err_pulse high 1 cycle, err_cnt=1, first_err_cyc=5, pass=0.
//  T3 CNT_W=4, z_dut=~aligned z_ref for 20 cycles
//     -> err_cnt=15 (saturated), err_pulse high all 20 cycles, pass=0.
//  T4 LATENCY=3, z_ref toggling, z_dut=z_ref delayed 3 -> err_cnt=0.
//     Same stream delayed 2 -> err_cnt>0 -> checks the alignment.
//  T5 start, stop during SETTLE -> back to IDLE, done=0. Start again, stop at
//     CHECK cycle 4 with start pulsed at cycle 2 -> start ignored, done=1, match_cnt=5.
//  T6 rst_n=0 for 1 cycle mid-CHECK after 3 errors -> next cycle IDLE, err_cnt=0,
//     done=0, first_err_cyc=all-ones.

Source files
------------

// File: rtl/vlg_resp_checker.sv
// Response checker: delays the reference output z_ref by LATENCY clocks and
// compares it against a registered DUT output z_dut during a check run.
// It reports a per-cycle mismatch pulse, saturating error and match counts,
// the CHECK-cycle index of the first mismatch, and a final pass flag.
module vlg_resp_checker #(
  parameter int LATENCY = 1,   // clocks z_dut lags z_ref, 1..8
  parameter int CNT_W   = 16   // width of all counters
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             z_ref,
  input  logic             z_dut,
  output logic             chk_active,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // SETTLE lasts exactly LATENCY cycles: the counter runs 0..LATENCY-1.
  localparam logic [2:0]       SETTLE_LAST = 3'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ALL1    = '1;

  state_t             state_q, state_d;
  logic [2:0]         settle_q, settle_d;
  logic [LATENCY-1:0] tap_q, tap_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]   first_err_q, first_err_d;
  logic               pass_q, pass_d;
  logic               z_aln;
  logic               mismatch;
  logic               clr_run;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_ALL1) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  assign z_aln    = tap_q[LATENCY-1];
  assign mismatch = z_aln ^ z_dut;

  // Delay line of z_ref: shifts on every edge regardless of FSM state.
  always_comb begin
    tap_d    = tap_q;
    tap_d[0] = z_ref;
    for (int i = 1; i < LATENCY; i++) begin
      tap_d[i] = tap_q[i-1];
    end
  end

  // Next-state and run bookkeeping; a start from IDLE/DONE clears the run.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    match_cnt_d = match_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    clr_run     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          clr_run = 1'b1;
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_pulse_d = 1'b1;
          err_cnt_d   = sat_inc(err_cnt_q);
          if (err_cnt_q == CNT_ZERO) begin
            first_err_d = cyc_cnt_q;
          end
        end else begin
          match_cnt_d = sat_inc(match_cnt_q);
        end
        cyc_cnt_d = sat_inc(cyc_cnt_q);
        // The compare on the stop edge still counts toward the verdict.
        if (stop) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == CNT_ZERO);
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          clr_run = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clr_run) begin
      settle_d    = 3'd0;
      err_cnt_d   = CNT_ZERO;
      match_cnt_d = CNT_ZERO;
      cyc_cnt_d   = CNT_ZERO;
      first_err_d = CNT_ALL1;
      pass_d      = 1'b0;
    end
  end

  // State, delay line and counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      settle_q    <= 3'd0;
      tap_q       <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= CNT_ZERO;
      match_cnt_q <= CNT_ZERO;
      cyc_cnt_q   <= CNT_ZERO;
      first_err_q <= CNT_ALL1;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      tap_q       <= tap_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign chk_active    = (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign err_pulse     = err_pulse_q;
  assign err_cnt       = err_cnt_q;
  assign match_cnt     = match_cnt_q;
  assign first_err_cyc = first_err_q;
  assign pass          = pass_q;

endmodule
